// File: rtl/core_ifetch.sv
// Instruction fetch: issues the PC on the instruction bus, keeps in-order responses
// with their PCs in a small queue and hands them to decode over valid/ready.
module core_ifetch #(
    parameter int unsigned DATA_BUS_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH     = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DATA_BUS_WIDTH-1:0] pc_i,
    input  logic                      flush_i,
    output logic                      hold_flag_o,
    output logic                      ibus_req_o,
    output logic [DATA_BUS_WIDTH-1:0] ibus_addr_o,
    input  logic                      ibus_gnt_i,
    input  logic                      ibus_rvalid_i,
    input  logic [DATA_BUS_WIDTH-1:0] ibus_rdata_i,
    output logic                      inst_valid_o,
    output logic [DATA_BUS_WIDTH-1:0] inst_o,
    output logic [DATA_BUS_WIDTH-1:0] inst_pc_o,
    input  logic                      inst_ready_i
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BUS_WIDTH-1:0] ent_pc   [FIFO_DEPTH];
    logic [DATA_BUS_WIDTH-1:0] ent_inst [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]     ent_valid;
    logic [FIFO_DEPTH-1:0]     ent_filled;

    logic [PW-1:0] alloc_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] head_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] discard_cnt;

    logic [CW:0]   in_use;
    logic          alloc;
    logic          pop;
    logic          fill_ok;
    logic          drop;
    logic [CW-1:0] unfilled;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] flush_discard;

    // Outstanding requests (live or to-be-discarded) bound the request window.
    assign in_use      = (CW+1)'(count) + (CW+1)'(discard_cnt);
    assign ibus_req_o  = ~rst_i & ~flush_i & (in_use < (CW+1)'(FIFO_DEPTH));
    assign ibus_addr_o = pc_i;
    assign alloc       = ibus_req_o & ibus_gnt_i;
    assign hold_flag_o = ~alloc;

    assign inst_valid_o = ent_valid[head_ptr] & ent_filled[head_ptr];
    assign inst_o       = ent_inst[head_ptr];
    assign inst_pc_o    = ent_pc[head_ptr];
    assign pop          = inst_valid_o & inst_ready_i & ~flush_i;

    assign fill_ok = ibus_rvalid_i & (discard_cnt == '0)
                     & ent_valid[fill_ptr] & ~ent_filled[fill_ptr];
    assign drop    = ibus_rvalid_i & (discard_cnt != '0);

    // Responses still owed by the bus once the queue is thrown away.
    always_comb begin
        unfilled = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            unfilled = unfilled + CW'(ent_valid[i] & ~ent_filled[i]);
        end
        outstanding   = discard_cnt + unfilled;
        flush_discard = outstanding;
        if (ibus_rvalid_i && (outstanding != '0)) begin
            flush_discard = outstanding - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_pc[i]   <= '0;
                ent_inst[i] <= '0;
            end
            ent_valid   <= '0;
            ent_filled  <= '0;
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            head_ptr    <= '0;
            count       <= '0;
            discard_cnt <= '0;
        end else if (flush_i) begin
            ent_valid   <= '0;
            ent_filled  <= '0;
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            head_ptr    <= '0;
            count       <= '0;
            discard_cnt <= flush_discard;
        end else begin
            // Alloc, fill and pop never target the same entry in one cycle.
            if (alloc) begin
                ent_pc[alloc_ptr]     <= pc_i;
                ent_valid[alloc_ptr]  <= 1'b1;
                ent_filled[alloc_ptr] <= 1'b0;
                alloc_ptr             <= alloc_ptr + PW'(1);
            end
            if (fill_ok) begin
                ent_inst[fill_ptr]   <= ibus_rdata_i;
                ent_filled[fill_ptr] <= 1'b1;
                fill_ptr             <= fill_ptr + PW'(1);
            end
            if (drop) begin
                discard_cnt <= discard_cnt - CW'(1);
            end
            if (pop) begin
                ent_valid[head_ptr]  <= 1'b0;
                ent_filled[head_ptr] <= 1'b0;
                head_ptr             <= head_ptr + PW'(1);
            end
            count <= count + CW'(alloc) - CW'(pop);
        end
    end

endmodule
